// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with per-register busy scoreboard.
// Ports: clk, rst (async, active-low); we/wa/wd write-back;
// ra1/ra2 -> rd1/rd2 + rv1/rv2 valid; issue_en/issue_wa -> issue_rdy;
// npend = number of registers currently pending.
module rf_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          rv1,
  output logic          rv2,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_wa,
  output logic          issue_rdy,
  output logic [AW:0]   npend
);

  localparam int NREG = 2 ** AW;
  localparam int NMAX = (ZERO_REG != 0) ? NREG - 1 : NREG;
  localparam logic [AW:0] NMAX_V = (AW + 1)'(NMAX);

  logic [DW-1:0]   r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_npend;

  logic            w_we;
  logic            w_wa_z;
  logic            w_iwa_z;
  logic            w_wr_ok;
  logic            w_set;
  logic            w_inc;
  logic            w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_npend_nxt;
  logic [1:0][AW-1:0] w_ra;
  logic [1:0][DW-1:0] w_rd;
  logic [1:0]         w_rv;

  // Write-back is masked while in reset so nothing forwards from it.
  assign w_we    = we & rst;
  assign w_wa_z  = (ZERO_REG != 0) && (wa == '0);
  assign w_iwa_z = (ZERO_REG != 0) && (issue_wa == '0);
  assign w_wr_ok = w_we & ~w_wa_z;

  assign issue_rdy = issue_en &
    (~r_busy[issue_wa] | (w_we & (wa == issue_wa)));

  // Claims of the hardwired zero register are accepted but not recorded.
  assign w_set = issue_rdy & ~w_iwa_z;

  // Track true 0->1 and 1->0 busy transitions; a claim on the
  // register being written wins, so that write clears nothing.
  assign w_inc = w_set & ~r_busy[issue_wa];
  assign w_clr = w_wr_ok & r_busy[wa] &
    ~(w_set & (issue_wa == wa));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) w_busy_nxt[wa] = 1'b0;
    if (w_set) w_busy_nxt[issue_wa] = 1'b1;
  end

  always_comb begin
    w_npend_nxt = r_npend;
    unique case ({w_inc, w_clr})
      2'b10: if (r_npend < NMAX_V) w_npend_nxt = r_npend + 1'b1;
      2'b01: if (r_npend != '0) w_npend_nxt = r_npend - 1'b1;
      default: w_npend_nxt = r_npend;
    endcase
  end

  assign w_ra = {ra2, ra1};

  always_comb begin
    w_rd = '0;
    w_rv = '0;
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_rf[w_ra[p]];
      w_rv[p] = ~r_busy[w_ra[p]];
      if ((BYPASS != 0) && w_we && (wa == w_ra[p])) begin
        w_rd[p] = wd;
        w_rv[p] = 1'b1;
      end
      if ((ZERO_REG != 0) && (w_ra[p] == '0)) begin
        w_rd[p] = '0;
        w_rv[p] = 1'b1;
      end
    end
  end

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign rv1   = w_rv[0];
  assign rv2   = w_rv[1];
  assign npend = r_npend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_busy  <= '0;
      r_npend <= '0;
    end else begin
      if (w_wr_ok) r_rf[wa] <= wd;
      r_busy  <= w_busy_nxt;
      r_npend <= w_npend_nxt;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed + random checks of rf_scoreboard
// against a behavioural register-file/scoreboard model.
module tb_rf_scoreboard;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        rv1, rv2;
  logic        issue_en;
  logic [4:0]  issue_wa;
  logic        issue_rdy;
  logic [5:0]  npend;

  logic        b_rst;
  logic        b_we;
  logic [2:0]  b_wa;
  logic [15:0] b_wd;
  logic [2:0]  b_ra1, b_ra2;
  logic [15:0] b_rd1, b_rd2;
  logic        b_rv1, b_rv2;
  logic        b_ie;
  logic [2:0]  b_iwa;
  logic        b_rdy;
  logic [3:0]  b_npend;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_rf [32];
  bit          m_busy [32];

  rf_scoreboard dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rv1(rv1), .rv2(rv2), .issue_en(issue_en),
    .issue_wa(issue_wa), .issue_rdy(issue_rdy), .npend(npend)
  );

  rf_scoreboard #(.DW(16), .AW(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(b_rst), .we(b_we), .wa(b_wa), .wd(b_wd),
    .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
    .rv1(b_rv1), .rv2(b_rv2), .issue_en(b_ie),
    .issue_wa(b_iwa), .issue_rdy(b_rdy), .npend(b_npend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic logic exp_rv(input logic [4:0] a);
    if (a == 0) return 1'b1;
    if (we && wa == a) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic logic exp_rdy();
    return issue_en && (!m_busy[issue_wa] || (we && wa == issue_wa));
  endfunction

  function automatic int popcnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic setin(input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] r1,
                       input logic [4:0] r2, input logic ie,
                       input logic [4:0] ia);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    issue_en = ie; issue_wa = ia;
  endtask

  // Called at a falling edge with inputs set; returns at the next one.
  task automatic step();
    logic rdy;
    #1;
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("rv1", 32'(rv1), 32'(exp_rv(ra1)));
    chk("rv2", 32'(rv2), 32'(exp_rv(ra2)));
    rdy = exp_rdy();
    chk("issue_rdy", 32'(issue_rdy), 32'(rdy));
    @(posedge clk);
    if (we && wa != 0) begin
      m_rf[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (rdy && issue_wa != 0) m_busy[issue_wa] = 1'b1;
    #1;
    chk("npend", 32'(npend), 32'(popcnt()));
    @(negedge clk);
  endtask

  // Pulse reset between edges, checking the cleared view during it.
  task automatic mid_reset(input logic [4:0] a);
    we = 1'b0; ra1 = a; issue_en = 1'b1; issue_wa = a;
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("rst_npend", 32'(npend), 32'h0);
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rv1", 32'(rv1), 32'h1);
    chk("rst_rdy", 32'(issue_rdy), 32'(exp_rdy()));
    #1 rst = 1'b1;
    issue_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bstep();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; b_rst = 1'b0;
    setin(1'b0, '0, '0, '0, '0, 1'b0, '0);
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra1 = '0; b_ra2 = '0;
    b_ie = 1'b0; b_iwa = '0;
    model_clear();
    @(negedge clk);
    chk("por_npend", 32'(npend), 32'h0);
    chk("por_rv1", 32'(rv1), 32'h1);
    chk("por_rd1", rd1, 32'h0);
    rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);

    setin(1'b1, 5'd5, 32'hDEADBEEF, '0, '0, 1'b0, '0);
    step();
    setin(1'b0, '0, '0, 5'd5, '0, 1'b0, '0);
    #1;
    chk("r5_rd1", rd1, 32'hDEADBEEF);
    chk("r5_rv1", 32'(rv1), 32'h1);
    chk("r5_npend", 32'(npend), 32'h0);
    step();

    setin(1'b0, '0, '0, '0, '0, 1'b1, 5'd3);
    #1 chk("claim3_rdy", 32'(issue_rdy), 32'h1);
    step();
    setin(1'b0, '0, '0, '0, 5'd3, 1'b0, '0);
    #1;
    chk("r3_rv2_busy", 32'(rv2), 32'h0);
    chk("r3_npend1", 32'(npend), 32'h1);
    step();
    setin(1'b0, '0, '0, '0, 5'd3, 1'b1, 5'd3);
    #1 chk("reclaim3_rdy", 32'(issue_rdy), 32'h0);
    step();
    setin(1'b1, 5'd3, 32'h12, '0, 5'd3, 1'b0, '0);
    #1;
    chk("byp_rd2", rd2, 32'h12);
    chk("byp_rv2", 32'(rv2), 32'h1);
    step();
    setin(1'b0, '0, '0, '0, 5'd3, 1'b0, '0);
    #1;
    chk("r3_rv2_done", 32'(rv2), 32'h1);
    chk("r3_npend0", 32'(npend), 32'h0);
    step();

    setin(1'b0, '0, '0, '0, '0, 1'b1, 5'd7);
    step();
    setin(1'b1, 5'd7, 32'h77, '0, '0, 1'b1, 5'd7);
    #1 chk("wc7_rdy", 32'(issue_rdy), 32'h1);
    step();
    setin(1'b0, '0, '0, 5'd7, '0, 1'b0, '0);
    #1;
    chk("wc7_rd1", rd1, 32'h77);
    chk("wc7_rv1", 32'(rv1), 32'h0);
    chk("wc7_npend", 32'(npend), 32'h1);
    step();
    setin(1'b1, 5'd7, 32'h78, '0, '0, 1'b0, '0);
    step();

    setin(1'b1, 5'd0, 32'hFFFFFFFF, '0, '0, 1'b0, '0);
    step();
    setin(1'b0, '0, '0, 5'd0, '0, 1'b1, 5'd0);
    #1 chk("claim0_rdy", 32'(issue_rdy), 32'h1);
    step();
    setin(1'b0, '0, '0, 5'd0, '0, 1'b0, '0);
    #1;
    chk("r0_rd1", rd1, 32'h0);
    chk("r0_rv1", 32'(rv1), 32'h1);
    chk("r0_npend", 32'(npend), 32'h0);
    step();

    setin(1'b1, 5'd1, 32'hAAAA, '0, '0, 1'b0, '0);
    step();
    setin(1'b0, '0, '0, '0, '0, 1'b1, 5'd1);
    step();
    setin(1'b0, '0, '0, '0, '0, 1'b1, 5'd2);
    step();
    setin(1'b0, '0, '0, '0, '0, 1'b1, 5'd4);
    step();
    setin(1'b0, '0, '0, 5'd1, '0, 1'b0, '0);
    #1 chk("three_npend", 32'(npend), 32'h3);
    @(negedge clk);
    mid_reset(5'd1);
    setin(1'b0, '0, '0, 5'd1, 5'd2, 1'b0, '0);
    step();

    for (int i = 0; i < 400; i++) begin
      logic [4:0] mx;
      mx = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
      setin(1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, int'(mx))), $urandom(),
            5'($urandom_range(0, int'(mx))),
            5'($urandom_range(0, int'(mx))),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, int'(mx))));
      step();
      if (i == 200) mid_reset(5'($urandom_range(1, 7)));
    end
    setin(1'b0, '0, '0, '0, '0, 1'b0, '0);

    for (int i = 1; i < 8; i++) begin
      b_ie = 1'b1; b_iwa = 3'(i);
      bstep();
    end
    b_ie = 1'b0;
    #1 chk("b_npend7", 32'(b_npend), 32'h7);
    @(negedge clk);
    b_we = 1'b1; b_wa = 3'd2; b_wd = 16'h1111;
    bstep();
    b_we = 1'b0; b_ie = 1'b1; b_iwa = 3'd2;
    bstep();
    b_ie = 1'b0;
    b_we = 1'b1; b_wa = 3'd2; b_wd = 16'h2222; b_ra1 = 3'd2;
    #1;
    chk("b_old_rd", 32'(b_rd1), 32'h1111);
    chk("b_old_rv", 32'(b_rv1), 32'h0);
    bstep();
    b_we = 1'b0;
    #1;
    chk("b_new_rd", 32'(b_rd1), 32'h2222);
    chk("b_new_rv", 32'(b_rv1), 32'h1);
    chk("b_npend6", 32'(b_npend), 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
